// File: rtl/processor_core_pkg.sv
// Shared types for the accumulator core: opcodes, FSM states, ALU selects
// and the default word widths.
package details;

  localparam int REG_WIDTH_DEF = 12;
  localparam int INS_WIDTH_DEF = 8;

  typedef enum logic [7:0] {
    OP_NOP    = 8'h00,
    OP_ENDOP  = 8'h01,
    OP_CLAC   = 8'h02,
    OP_INCAC  = 8'h03,
    OP_DECAC  = 8'h04,
    OP_LOADAC = 8'h05,
    OP_STAC   = 8'h06,
    OP_MVACAR = 8'h07,
    OP_MVACR  = 8'h08,
    OP_MVRAC  = 8'h09,
    OP_MVACR1 = 8'h0A,
    OP_MVR1AC = 8'h0B,
    OP_MVACR2 = 8'h0C,
    OP_MVR2AC = 8'h0D,
    OP_ADD    = 8'h10,
    OP_SUB    = 8'h11,
    OP_MUL    = 8'h12,
    OP_LDIAC  = 8'h20,
    OP_JUMP   = 8'h30,
    OP_JMPZ   = 8'h31,
    OP_JMPNZ  = 8'h32
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_LOADWAIT,
    S_OPER
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_CLR,
    ALU_INC,
    ALU_DEC,
    ALU_ADD,
    ALU_SUB,
    ALU_MUL
  } alu_op_e;

  // Ops whose operand k lives in the following instruction word.
  function automatic logic is_two_word(input logic [7:0] op);
    return (op == OP_LDIAC) || (op == OP_JUMP) || (op == OP_JMPZ) || (op == OP_JMPNZ);
  endfunction

endpackage

// File: rtl/processor_core_if.sv
// Instruction/data memory bus of one core; both memories read synchronously
// with one cycle of latency.
interface processor_core_if #(
  parameter int REG_WIDTH = 12,
  parameter int INS_WIDTH = 8
);
  logic [INS_WIDTH-1:0] insMemAddr;
  logic [INS_WIDTH-1:0] InsMemOut;
  logic [REG_WIDTH-1:0] dataMemAddr;
  logic [REG_WIDTH-1:0] DataMemOut;
  logic [REG_WIDTH-1:0] DataMemIn;
  logic                 DataMemWrEn;

  modport master (
    output insMemAddr, dataMemAddr, DataMemIn, DataMemWrEn,
    input  InsMemOut, DataMemOut
  );

  modport slave (
    input  insMemAddr, dataMemAddr, DataMemIn, DataMemWrEn,
    output InsMemOut, DataMemOut
  );
endinterface

// File: rtl/processor_core_alu.sv
// Combinational accumulator ALU; all arithmetic wraps modulo 2^REG_WIDTH.
module processor_core_alu
  import details::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input  alu_op_e              op_i,
  input  logic [REG_WIDTH-1:0] ac_i,
  input  logic [REG_WIDTH-1:0] r_i,
  output logic [REG_WIDTH-1:0] result_o,
  output logic                 zero_o
);

  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

  always_comb begin
    result_o = ac_i;
    unique case (op_i)
      ALU_CLR:  result_o = '0;
      ALU_INC:  result_o = ac_i + ONE;
      ALU_DEC:  result_o = ac_i - ONE;
      ALU_ADD:  result_o = ac_i + r_i;
      ALU_SUB:  result_o = ac_i - r_i;
      ALU_MUL:  result_o = ac_i * r_i;
      default:  result_o = ac_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/processor_core.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC sequencer with LOADWAIT for
// data reads and OPER for the immediate word of two-word instructions.
module processor_core
  import details::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int INS_WIDTH = INS_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  output logic              ready,
  output logic              done,
  processor_core_if.master  mem
);

  localparam logic [INS_WIDTH-1:0] PC_ONE = INS_WIDTH'(1);

  state_e               state_q, state_d;
  logic [INS_WIDTH-1:0] pc_q, pc_d;
  logic [INS_WIDTH-1:0] ir_q, ir_d;
  logic [REG_WIDTH-1:0] ac_q, ac_d;
  logic [REG_WIDTH-1:0] r_q, r_d;
  logic [REG_WIDTH-1:0] r1_q, r1_d;
  logic [REG_WIDTH-1:0] r2_q, r2_d;
  logic [REG_WIDTH-1:0] ar_q, ar_d;
  logic                 z_q, z_d;
  logic                 done_q, done_d;
  logic                 wr_en;

  alu_op_e              alu_op;
  logic [REG_WIDTH-1:0] alu_res;
  logic                 alu_zero;

  processor_core_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .op_i     (alu_op),
    .ac_i     (ac_q),
    .r_i      (r_q),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  always_comb begin
    alu_op = ALU_PASS;
    case (ir_q)
      OP_CLAC:  alu_op = ALU_CLR;
      OP_INCAC: alu_op = ALU_INC;
      OP_DECAC: alu_op = ALU_DEC;
      OP_ADD:   alu_op = ALU_ADD;
      OP_SUB:   alu_op = ALU_SUB;
      OP_MUL:   alu_op = ALU_MUL;
      default:  alu_op = ALU_PASS;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    r_d     = r_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    ar_d    = ar_q;
    z_d     = z_q;
    done_d  = done_q;
    wr_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          done_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = mem.InsMemOut;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (alu_op != ALU_PASS) begin
          ac_d = alu_res;
          z_d  = alu_zero;
        end
        case (ir_q)
          OP_ENDOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          OP_LOADAC: state_d = S_LOADWAIT;
          OP_STAC:   wr_en   = 1'b1;
          OP_MVACAR: ar_d    = ac_q;
          OP_MVACR:  r_d     = ac_q;
          OP_MVRAC:  ac_d    = r_q;
          OP_MVACR1: r1_d    = ac_q;
          OP_MVR1AC: ac_d    = r1_q;
          OP_MVACR2: r2_d    = ac_q;
          OP_MVR2AC: ac_d    = r2_q;
          default: ;
        endcase
        // The operand word is fetched now so it arrives during OPER.
        if (is_two_word(ir_q)) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_OPER;
        end
      end
      S_LOADWAIT: begin
        ac_d    = mem.DataMemOut;
        state_d = S_FETCH;
      end
      S_OPER: begin
        state_d = S_FETCH;
        case (ir_q)
          OP_LDIAC: ac_d = {{(REG_WIDTH-INS_WIDTH){1'b0}}, mem.InsMemOut};
          OP_JUMP:  pc_d = mem.InsMemOut;
          OP_JMPZ:  if (z_q)  pc_d = mem.InsMemOut;
          OP_JMPNZ: if (!z_q) pc_d = mem.InsMemOut;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      r_q     <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      ar_q    <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      r_q     <= r_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ar_q    <= ar_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign mem.insMemAddr  = pc_q;
  assign mem.dataMemAddr = ar_q;
  assign mem.DataMemIn   = ac_q;
  // Gated by rstN so a reset landing on a STAC cycle never reaches memory.
  assign mem.DataMemWrEn = wr_en & rstN;
  assign ready           = (state_q == S_IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_processor_core.sv
// Randomized bench for processor_core: instruction-level reference model run
// against the core with behavioural synchronous memories.
module tb_processor_core;

  logic clk = 1'b0;
  logic rstN;
  logic start;
  logic ready;
  logic done;

  processor_core_if #(.REG_WIDTH(12), .INS_WIDTH(8)) mif ();

  processor_core #(.REG_WIDTH(12), .INS_WIDTH(8)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .ready (ready),
    .done  (done),
    .mem   (mif)
  );

  always #5 clk = ~clk;

  logic [7:0]  im [256];
  logic [11:0] dm [4096];
  logic [11:0] obs_wa [$];
  logic [11:0] obs_wd [$];

  always @(posedge clk) begin
    mif.InsMemOut  <= im[mif.insMemAddr];
    mif.DataMemOut <= dm[mif.dataMemAddr];
    if (mif.DataMemWrEn === 1'b1) begin
      dm[mif.dataMemAddr] = mif.DataMemIn;
      obs_wa.push_back(mif.dataMemAddr);
      obs_wd.push_back(mif.DataMemIn);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural state of the reference machine.
  bit [11:0] m_ac, m_r, m_r1, m_r2, m_ar;
  bit        m_z;
  bit [11:0] mdm [4096];
  bit [11:0] exp_wa [$];
  bit [11:0] exp_wd [$];

  task automatic model_reset();
    m_ac = 0; m_r = 0; m_r1 = 0; m_r2 = 0; m_ar = 0; m_z = 0;
  endtask

  task automatic model_run(output int cyc);
    bit [7:0] pc, op, k;
    int steps;
    bit fin;
    pc = 0; steps = 0; fin = 0; cyc = 0;
    exp_wa.delete(); exp_wd.delete();
    while (!fin && steps < 5000) begin
      steps++;
      op = im[pc];
      pc = pc + 8'd1;
      if (op == 8'h20 || op == 8'h30 || op == 8'h31 || op == 8'h32) begin
        k = im[pc];
        pc = pc + 8'd1;
        cyc += 4;
        case (op)
          8'h20: m_ac = {4'h0, k};
          8'h30: pc = k;
          8'h31: if (m_z) pc = k;
          default: if (!m_z) pc = k;
        endcase
      end else begin
        cyc += (op == 8'h05) ? 4 : 3;
        case (op)
          8'h01: fin = 1;
          8'h02: begin m_ac = 0;           m_z = (m_ac == 0); end
          8'h03: begin m_ac = m_ac + 12'd1; m_z = (m_ac == 0); end
          8'h04: begin m_ac = m_ac - 12'd1; m_z = (m_ac == 0); end
          8'h05: m_ac = mdm[m_ar];
          8'h06: begin mdm[m_ar] = m_ac; exp_wa.push_back(m_ar); exp_wd.push_back(m_ac); end
          8'h07: m_ar = m_ac;
          8'h08: m_r = m_ac;
          8'h09: m_ac = m_r;
          8'h0A: m_r1 = m_ac;
          8'h0B: m_ac = m_r1;
          8'h0C: m_r2 = m_ac;
          8'h0D: m_ac = m_r2;
          8'h10: begin m_ac = m_ac + m_r; m_z = (m_ac == 0); end
          8'h11: begin m_ac = m_ac - m_r; m_z = (m_ac == 0); end
          8'h12: begin m_ac = m_ac * m_r; m_z = (m_ac == 0); end
          default: ;
        endcase
      end
    end
    if (!fin) cyc = -1;
  endtask

  task automatic load_prog(input logic [7:0] p [$]);
    for (int i = 0; i < 256; i++) im[i] = 8'h01;
    foreach (p[i]) im[i] = p[i];
  endtask

  // Starts the loaded program, waits for ready, and checks against the model.
  task automatic run_prog(input string tag, input bit pulse, output int cnt);
    int exp_cyc;
    model_run(exp_cyc);
    obs_wa.delete(); obs_wd.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 5000) begin
      start = (pulse && cnt == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check_eq({tag, "_cycles"}, cnt, exp_cyc);
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_ac"}, {20'd0, mif.DataMemIn}, {20'd0, m_ac});
    check_eq({tag, "_ar"}, {20'd0, mif.dataMemAddr}, {20'd0, m_ar});
    check_eq({tag, "_nwr"}, obs_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
      check_eq($sformatf("%s_wa%0d", tag, i), {20'd0, obs_wa[i]}, {20'd0, exp_wa[i]});
      check_eq($sformatf("%s_wd%0d", tag, i), {20'd0, obs_wd[i]}, {20'd0, exp_wd[i]});
    end
  endtask

  initial begin
    logic [7:0] p [$];
    int cnt, n, diff;
    logic [7:0] op;
    logic [7:0] ops [22];

    ops = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B,
            8'h0C, 8'h0D, 8'h10, 8'h11, 8'h12, 8'h20, 8'h30, 8'h31, 8'h32, 8'h0E, 8'hFF};
    rstN = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      dm[i] = 12'($urandom);
      mdm[i] = dm[i];
    end
    for (int i = 0; i < 256; i++) im[i] = 8'h01;
    model_reset();
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wren", {31'd0, mif.DataMemWrEn}, 32'd0);
    check_eq("rst_ac", {20'd0, mif.DataMemIn}, 32'd0);
    check_eq("rst_ar", {20'd0, mif.dataMemAddr}, 32'd0);

    p = '{8'h01};
    load_prog(p);
    run_prog("endop", 1'b0, cnt);
    check_eq("endop_cyc3", cnt, 32'd3);

    p = '{8'h20, 8'h05, 8'h08, 8'h20, 8'h07, 8'h10, 8'h06, 8'h01};
    load_prog(p);
    run_prog("add12", 1'b0, cnt);
    check_eq("add12_nwr", obs_wa.size(), 32'd1);
    if (obs_wa.size() == 1) begin
      check_eq("add12_addr", {20'd0, obs_wa[0]}, 32'd0);
      check_eq("add12_data", {20'd0, obs_wd[0]}, 32'd12);
    end

    dm[3] = 12'hFFF; mdm[3] = 12'hFFF;
    p = '{8'h20, 8'h03, 8'h07, 8'h05, 8'h03, 8'h01};
    load_prog(p);
    run_prog("ldwrap", 1'b0, cnt);
    check_eq("ldwrap_ac0", {20'd0, mif.DataMemIn}, 32'd0);
    check_eq("ldwrap_nowr", obs_wa.size(), 32'd0);

    p = '{8'h20, 8'h03, 8'h04, 8'h32, 8'h02, 8'h01};
    load_prog(p);
    run_prog("loop", 1'b0, cnt);
    check_eq("loop_cyc28", cnt, 32'd28);
    check_eq("loop_ac0", {20'd0, mif.DataMemIn}, 32'd0);

    // 0x80*0x10 = 0x800, then 0x800*2 wraps to 0; JMPZ then skips the INCAC.
    p = '{8'h20, 8'h80, 8'h08, 8'h20, 8'h10, 8'h12, 8'h08, 8'h20, 8'h02, 8'h12,
          8'h31, 8'h0D, 8'h03, 8'h01};
    load_prog(p);
    run_prog("mul", 1'b1, cnt);
    check_eq("mul_ac0", {20'd0, mif.DataMemIn}, 32'd0);

    // Reset on the STAC execute cycle must suppress the write.
    dm[5] = 12'h123; mdm[5] = 12'h123;
    p = '{8'h20, 8'h05, 8'h07, 8'h20, 8'h09, 8'h06, 8'h01};
    load_prog(p);
    obs_wa.delete(); obs_wd.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (mif.DataMemWrEn !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("rstst_reached", {31'd0, mif.DataMemWrEn}, 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    model_reset();
    check_eq("rstst_nowr", obs_wa.size(), 32'd0);
    check_eq("rstst_dm5", {20'd0, dm[5]}, 32'h123);
    check_eq("rstst_ready", {31'd0, ready}, 32'd1);
    check_eq("rstst_done", {31'd0, done}, 32'd0);
    check_eq("rstst_wren", {31'd0, mif.DataMemWrEn}, 32'd0);
    check_eq("rstst_ac", {20'd0, mif.DataMemIn}, 32'd0);
    check_eq("rstst_ar", {20'd0, mif.dataMemAddr}, 32'd0);
    run_prog("rstst_rerun", 1'b0, cnt);

    // Random programs with forward-only jumps so every program terminates.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(24, 4);
      p.delete();
      for (int i = 0; i < n; i++) begin
        op = ops[$urandom_range(21, 0)];
        if (op == 8'h20 || op == 8'h30 || op == 8'h31 || op == 8'h32) begin
          if (i + 1 >= n) op = 8'h03;
        end
        p.push_back(op);
        if (op == 8'h20) begin
          p.push_back(8'($urandom));
          i++;
        end else if (op == 8'h30 || op == 8'h31 || op == 8'h32) begin
          p.push_back(8'($urandom_range(n, i + 2)));
          i++;
        end
      end
      p.push_back(8'h01);
      load_prog(p);
      run_prog($sformatf("rnd%0d", t), t[0], cnt);
    end

    diff = 0;
    for (int i = 0; i < 4096; i++) if (dm[i] != mdm[i]) diff++;
    check_eq("final_dmem_diff", diff, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
